// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline front end: widths, opcodes,
// fetch FSM encoding and the skid-buffer entry layout.
package wisc_pkg;

    localparam int                 INST_W   = 16;
    localparam logic [3:0]         OPC_HLT  = 4'hF;
    localparam logic [INST_W-1:0]  PC_INC   = 16'd2;
    localparam logic [INST_W-1:0]  NOP_INST = 16'h0000;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t FULL  = 2'd1;
    localparam fetch_state_t HALT  = 2'd2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc_next;
    } skid_entry_t;

    function automatic logic is_opcode(input logic [INST_W-1:0] inst,
                                       input logic [3:0]        opc);
        return (inst[INST_W-1 -: 4] == opc);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction response that arrived while
// decode was stalled; clear takes priority over load.
module fetch_skid_buf
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  skid_entry_t wr_entry,
    output logic        full,
    output skid_entry_t rd_entry
);

    logic        full_r;
    skid_entry_t entry_r;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r  <= 1'b0;
            entry_r <= '{inst: NOP_INST, pc_next: 16'h0000};
        end else if (clear) begin
            full_r  <= 1'b0;
        end else if (load) begin
            full_r  <= 1'b1;
            entry_r <= wr_entry;
        end
    end

    assign full     = full_r;
    assign rd_entry = entry_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over a
// req/ready handshake and feeds the IF/ID register.
module fetch_stage
    import wisc_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]        HLT_OPCODE = OPC_HLT,
    parameter logic [INST_W-1:0] PC_INC     = wisc_pkg::PC_INC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [INST_W-1:0] branch_target,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] if_id_inst,
    output logic [INST_W-1:0] if_id_pc_next,
    output logic              if_id_valid,
    output logic              halted
);

    fetch_state_t      state_r;
    logic [INST_W-1:0] pc_r;
    logic              imem_req_r;
    logic [INST_W-1:0] imem_addr_r;
    logic [INST_W-1:0] if_id_inst_r;
    logic [INST_W-1:0] if_id_pc_next_r;
    logic              if_id_valid_r;
    logic              halted_r;
    logic              drop_r;

    fetch_state_t      nxt_state_s;
    logic [INST_W-1:0] nxt_pc_s;
    logic              nxt_req_s;
    logic [INST_W-1:0] nxt_addr_s;
    logic [INST_W-1:0] nxt_inst_s;
    logic [INST_W-1:0] nxt_pcn_s;
    logic              nxt_valid_s;
    logic              nxt_halted_s;
    logic              nxt_drop_s;

    logic              complete_s;
    logic              redirect_s;
    logic [INST_W-1:0] addr_inc_s;
    logic              resp_hlt_s;
    logic              skid_hlt_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic              skid_full_s;
    skid_entry_t       skid_wr_s;
    skid_entry_t       skid_rd_s;

    assign complete_s = imem_req_r & imem_ready;
    assign redirect_s = branch_taken & if_id_valid_r & ~stall;
    // 16-bit add: 16'hFFFE wraps to 16'h0000 by design.
    assign addr_inc_s = imem_addr_r + PC_INC;
    assign resp_hlt_s = is_opcode(imem_data, HLT_OPCODE);
    assign skid_hlt_s = is_opcode(skid_rd_s.inst, HLT_OPCODE);
    assign skid_wr_s  = '{inst: imem_data, pc_next: addr_inc_s};

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load_s),
        .clear    (skid_clear_s),
        .wr_entry (skid_wr_s),
        .full     (skid_full_s),
        .rd_entry (skid_rd_s)
    );

    // Next-state logic; priority is redirect, then stall, then HLT, then advance.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_pc_s     = pc_r;
        nxt_req_s    = imem_req_r;
        nxt_addr_s   = imem_addr_r;
        nxt_inst_s   = if_id_inst_r;
        nxt_pcn_s    = if_id_pc_next_r;
        nxt_valid_s  = if_id_valid_r;
        nxt_halted_s = halted_r;
        nxt_drop_s   = drop_r;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;

        if (redirect_s) begin
            nxt_state_s  = FETCH;
            nxt_halted_s = 1'b0;
            nxt_valid_s  = 1'b0;
            nxt_pc_s     = branch_target;
            skid_clear_s = 1'b1;
            // An in-flight request cannot be withdrawn, so mark its data for discard.
            if (imem_req_r && !imem_ready) begin
                nxt_drop_s = 1'b1;
            end else begin
                nxt_drop_s = 1'b0;
                nxt_req_s  = 1'b1;
                nxt_addr_s = branch_target;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (complete_s && drop_r) begin
                        nxt_drop_s  = 1'b0;
                        nxt_req_s   = 1'b1;
                        nxt_addr_s  = pc_r;
                        nxt_valid_s = if_id_valid_r & stall;
                    end else if (complete_s && stall) begin
                        skid_load_s = 1'b1;
                        nxt_state_s = FULL;
                        nxt_req_s   = 1'b0;
                        nxt_pc_s    = addr_inc_s;
                        nxt_addr_s  = addr_inc_s;
                    end else if (complete_s) begin
                        nxt_inst_s  = imem_data;
                        nxt_pcn_s   = addr_inc_s;
                        nxt_valid_s = 1'b1;
                        nxt_pc_s    = addr_inc_s;
                        nxt_addr_s  = addr_inc_s;
                        if (resp_hlt_s) begin
                            nxt_state_s  = HALT;
                            nxt_halted_s = 1'b1;
                            nxt_req_s    = 1'b0;
                        end else begin
                            nxt_req_s    = 1'b1;
                        end
                    end else begin
                        nxt_valid_s = if_id_valid_r & stall;
                        if (!imem_req_r) begin
                            nxt_req_s  = 1'b1;
                            nxt_addr_s = pc_r;
                        end else begin
                            nxt_req_s  = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (!skid_full_s) begin
                        nxt_state_s = FETCH;
                        nxt_req_s   = 1'b1;
                        nxt_addr_s  = pc_r;
                    end else if (!stall) begin
                        skid_clear_s = 1'b1;
                        nxt_inst_s   = skid_rd_s.inst;
                        nxt_pcn_s    = skid_rd_s.pc_next;
                        nxt_valid_s  = 1'b1;
                        if (skid_hlt_s) begin
                            nxt_state_s  = HALT;
                            nxt_halted_s = 1'b1;
                            nxt_req_s    = 1'b0;
                        end else begin
                            nxt_state_s  = FETCH;
                            nxt_req_s    = 1'b1;
                            nxt_addr_s   = pc_r;
                        end
                    end else begin
                        nxt_req_s = 1'b0;
                    end
                end
                HALT: begin
                    nxt_req_s    = 1'b0;
                    nxt_halted_s = 1'b1;
                    nxt_valid_s  = if_id_valid_r & stall;
                end
                default: begin
                    nxt_state_s  = FETCH;
                    nxt_req_s    = 1'b0;
                    nxt_valid_s  = 1'b0;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // State, PC, memory request and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= FETCH;
            pc_r            <= RESET_PC;
            imem_req_r      <= 1'b0;
            imem_addr_r     <= RESET_PC;
            if_id_inst_r    <= NOP_INST;
            if_id_pc_next_r <= 16'h0000;
            if_id_valid_r   <= 1'b0;
            halted_r        <= 1'b0;
            drop_r          <= 1'b0;
        end else begin
            state_r         <= nxt_state_s;
            pc_r            <= nxt_pc_s;
            imem_req_r      <= nxt_req_s;
            imem_addr_r     <= nxt_addr_s;
            if_id_inst_r    <= nxt_inst_s;
            if_id_pc_next_r <= nxt_pcn_s;
            if_id_valid_r   <= nxt_valid_s;
            halted_r        <= nxt_halted_s;
            drop_r          <= nxt_drop_s;
        end
    end

    assign imem_req      = imem_req_r;
    assign imem_addr     = imem_addr_r;
    assign if_id_inst    = if_id_inst_r;
    assign if_id_pc_next = if_id_pc_next_r;
    assign if_id_valid   = if_id_valid_r;
    assign halted        = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random-latency memory, random stall/branch from a
// decode stand-in, and a program-order reference model feeding a scoreboard.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc_next;
    logic        if_id_valid;
    logic        halted;

    int          pass_cnt;
    int          total_cnt;
    logic [15:0] mem_arr [0:32767];
    logic [15:0] exp_q [$];
    logic [15:0] cur_pc;
    bit          model_halt;
    int          consumed;
    int          mode;
    int          lat_min;
    int          lat_max;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .if_id_inst    (if_id_inst),
        .if_id_pc_next (if_id_pc_next),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [15:0] rand_word();
        return {4'($urandom_range(0, 14)), 12'($urandom)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", {16'd0, imem_addr}, 32'h0000);
        check("rst_if_id_inst", {16'd0, if_id_inst}, 32'h0000);
        check("rst_if_id_pc_next", {16'd0, if_id_pc_next}, 32'h0000);
        check("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        exp_q.delete();
        exp_q.push_back(16'h0000);
        cur_pc     = 16'h0000;
        model_halt = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Instruction memory: one request at a time, random latency, protocol checks.
    initial begin
        bit          busy;
        int          wait_left;
        logic [15:0] req_addr;
        busy = 1'b0;
        wait_left = 0;
        req_addr = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy       = 1'b0;
                imem_ready = 1'b0;
            end else begin
                if (imem_ready) busy = 1'b0;
                imem_ready = 1'b0;
                imem_data  = 16'($urandom);
                if (imem_req) begin
                    if (!busy) begin
                        busy      = 1'b1;
                        req_addr  = imem_addr;
                        wait_left = $urandom_range(lat_min, lat_max);
                    end else begin
                        check("imem_addr_stable", {16'd0, imem_addr}, {16'd0, req_addr});
                    end
                    if (wait_left == 0) begin
                        imem_ready = 1'b1;
                        imem_data  = mem_arr[req_addr[15:1]];
                    end else begin
                        wait_left--;
                    end
                end else if (busy) begin
                    check("imem_req_withdrawn", {31'd0, imem_req}, 32'd1);
                    busy = 1'b0;
                end
            end
        end
    end

    // Decode stand-in plus program-order model: on each consumption, push the next address.
    initial begin
        logic [15:0] w;
        logic [15:0] nxt;
        forever begin
            @(negedge clk);
            case (mode)
                1: begin
                    stall         = ($urandom_range(0, 3) == 0);
                    branch_taken  = ($urandom_range(0, 5) == 0);
                    branch_target = ($urandom_range(0, 15) == 0) ? 16'hFFFE
                                                                 : {7'd0, 8'($urandom), 1'b0};
                end
                2: begin
                    stall         = 1'b0;
                    branch_taken  = if_id_valid && (if_id_inst == 16'hB123);
                    branch_target = 16'h0020;
                end
                3: begin
                    stall        = 1'b1;
                    branch_taken = 1'b0;
                end
                default: begin
                    stall        = 1'b0;
                    branch_taken = 1'b0;
                end
            endcase
            if (rst_n && if_id_valid && !stall) begin
                consumed++;
                if (!model_halt) begin
                    w = mem_arr[cur_pc[15:1]];
                    if (branch_taken) begin
                        nxt = branch_target;
                        exp_q.push_back(nxt);
                        cur_pc = nxt;
                    end else if (w[15:12] == 4'hF) begin
                        model_halt = 1'b1;
                    end else begin
                        nxt = cur_pc + 16'd2;
                        exp_q.push_back(nxt);
                        cur_pc = nxt;
                    end
                end
            end
        end
    end

    // Monitor: every instruction decode consumes is compared with the model's next entry.
    initial begin
        logic [15:0] pc;
        logic [15:0] pcn;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && if_id_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_inst: got inst %0h pc_next %0h, required no instruction",
                             if_id_inst, if_id_pc_next);
                end else begin
                    pc  = exp_q.pop_front();
                    pcn = pc + 16'd2;
                    check("if_id_inst", {16'd0, if_id_inst}, {16'd0, mem_arr[pc[15:1]]});
                    check("if_id_pc_next", {16'd0, if_id_pc_next}, {16'd0, pcn});
                end
            end
        end
    end

    initial begin
        int c0;
        clk = 1'b0; rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0000; imem_ready = 1'b0; imem_data = 16'h0000;
        pass_cnt = 0; total_cnt = 0; consumed = 0; mode = 0;
        lat_min = 0; lat_max = 0; cur_pc = 16'h0000; model_halt = 1'b0;
        for (int i = 0; i < 32768; i++) mem_arr[i] = rand_word();
        mem_arr[0] = 16'h1123;
        mem_arr[1] = 16'h2234;
        mem_arr[2] = 16'h3345;

        // Zero-wait memory: back-to-back addresses and one instruction per cycle.
        #1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("zw_imem_req", {31'd0, imem_req}, 32'd1);
            check("zw_imem_addr", {16'd0, imem_addr}, 32'(2 * i));
        end
        c0 = consumed;
        repeat (12) @(negedge clk);
        #2;
        check("zw_rate", 32'(consumed - c0), 32'd12);

        // HLT at 0x0008 stops fetch.
        mem_arr[4] = 16'hF000;
        do_reset();
        for (int k = 0; k < 50 && !halted; k++) begin
            @(negedge clk);
            #2;
        end
        check("hlt_halted", {31'd0, halted}, 32'd1);
        check("hlt_inst", {16'd0, if_id_inst}, 32'hF000);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #2;
            check("hlt_imem_req", {31'd0, imem_req}, 32'd0);
        end
        check("hlt_still_halted", {31'd0, halted}, 32'd1);

        // Taken branch just ahead of the HLT: wrong-path HLT must not halt.
        mem_arr[3] = 16'hB123;
        mode = 2;
        do_reset();
        c0 = consumed;
        repeat (30) @(negedge clk);
        #2;
        check("bh_halted", {31'd0, halted}, 32'd0);
        check("bh_progress", {31'd0, (consumed - c0) >= 20}, 32'd1);
        mem_arr[3] = rand_word();
        mem_arr[4] = rand_word();

        // Response under stall goes to the buffer and fetch pauses.
        mode = 3;
        do_reset();
        repeat (6) @(negedge clk);
        #2;
        check("stall_imem_req", {31'd0, imem_req}, 32'd0);
        mode = 0;
        c0 = consumed;
        repeat (10) @(negedge clk);
        #2;
        check("stall_release_progress", {31'd0, (consumed - c0) >= 5}, 32'd1);

        // Fixed three-cycle memory: one instruction every three cycles.
        lat_min = 2;
        lat_max = 2;
        do_reset();
        repeat (10) @(negedge clk);
        #2;
        c0 = consumed;
        repeat (30) @(negedge clk);
        #2;
        check("lat3_rate", 32'(consumed - c0), 32'd10);

        // Random latency, stalls and redirects.
        lat_min = 0;
        lat_max = 3;
        mode = 1;
        do_reset();
        c0 = consumed;
        repeat (1500) @(negedge clk);
        #2;
        check("rand_progress_a", {31'd0, (consumed - c0) >= 100}, 32'd1);

        // Reset while a request is outstanding.
        for (int k = 0; k < 50; k++) begin
            if (imem_req && !imem_ready) break;
            @(negedge clk);
            #2;
        end
        do_reset();
        @(negedge clk);
        #2;
        check("post_rst_imem_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_imem_addr", {16'd0, imem_addr}, 32'h0000);
        c0 = consumed;
        repeat (1500) @(negedge clk);
        #2;
        check("rand_progress_b", {31'd0, (consumed - c0) >= 100}, 32'd1);

        mode = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
